// File: rtl/cr_huf_comp_is_multi_pkg.sv
// Shared types and default sizing for the Huffman symbol-sort block.
package cr_huf_compPKG;

  localparam int unsigned DefDatWidth        = 6;
  localparam int unsigned DefCntWidth        = 10;
  localparam int unsigned DefNLanes          = 4;
  localparam int unsigned DefMaxNumSymUsed   = 16;
  localparam int unsigned CreoleHcSeqidWidth = 8;

  typedef enum logic [1:0] {
    StAccept,
    StInsert,
    StDrain
  } is_state_e;

  // Bits needed to hold a count in 0..n.
  function automatic int unsigned count_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cr_huf_comp_is_multi_ins.sv
// Combinational sorted insert: finds the slot for one new entry and shifts the tail up by one.
module cr_huf_comp_is_multi_ins
  import cr_huf_compPKG::*;
#(
  parameter int unsigned DAT_WIDTH = DefDatWidth,
  parameter int unsigned CNT_WIDTH = DefCntWidth,
  parameter int unsigned DEPTH     = DefMaxNumSymUsed,
  parameter int unsigned UW        = count_width(DefMaxNumSymUsed)
) (
  input  logic [DEPTH-1:0][DAT_WIDTH-1:0] tbl_sym,
  input  logic [DEPTH-1:0][CNT_WIDTH-1:0] tbl_freq,
  input  logic [UW-1:0]                   used,
  input  logic [DAT_WIDTH-1:0]            new_sym,
  input  logic [CNT_WIDTH-1:0]            new_freq,
  output logic [DEPTH-1:0][DAT_WIDTH-1:0] ins_sym,
  output logic [DEPTH-1:0][CNT_WIDTH-1:0] ins_freq,
  output logic                            dup
);

  logic [UW-1:0] pos;

  // Slot = number of live entries ordered before the new one (freq, then symbol).
  always_comb begin
    dup = 1'b0;
    pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (UW'(i) < used) begin
        if (tbl_sym[i] == new_sym) dup = 1'b1;
        if ((tbl_freq[i] < new_freq) ||
            ((tbl_freq[i] == new_freq) && (tbl_sym[i] < new_sym))) begin
          pos = pos + UW'(1);
        end
      end
    end
  end

  // Entries below the slot stay, the slot takes the new entry, the rest move up one.
  always_comb begin
    ins_sym  = tbl_sym;
    ins_freq = tbl_freq;
    for (int i = 0; i < DEPTH; i++) begin
      int unsigned j;
      j = (i == 0) ? 0 : i - 1;
      if (UW'(i) < pos) begin
        ins_sym[i]  = tbl_sym[i];
        ins_freq[i] = tbl_freq[i];
      end else if (UW'(i) == pos) begin
        ins_sym[i]  = new_sym;
        ins_freq[i] = new_freq;
      end else begin
        ins_sym[i]  = tbl_sym[j];
        ins_freq[i] = tbl_freq[j];
      end
    end
  end

endmodule

// File: rtl/cr_huf_comp_is_multi.sv
// Collects (symbol, count) lanes of a block into a frequency-sorted table, then drains it.
module cr_huf_comp_is_multi
  import cr_huf_compPKG::*;
#(
  parameter int unsigned DAT_WIDTH        = DefDatWidth,
  parameter int unsigned CNT_WIDTH        = DefCntWidth,
  parameter int unsigned N_LANES          = DefNLanes,
  parameter int unsigned MAX_NUM_SYM_USED = DefMaxNumSymUsed,
  parameter int unsigned SEQID_WIDTH      = CreoleHcSeqidWidth
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_LANES-1:0]             sc_is_vld,
  input  logic [N_LANES*DAT_WIDTH-1:0]   sc_is_sym,
  input  logic [N_LANES*CNT_WIDTH-1:0]   sc_is_cnt,
  input  logic [SEQID_WIDTH-1:0]         sc_is_seq_id,
  input  logic                           sc_is_eob,
  output logic                           is_sc_rd,
  input  logic                           ht_is_not_ready,
  output logic                           is_ht_vld,
  output logic [DAT_WIDTH-1:0]           is_ht_sym,
  output logic [CNT_WIDTH-1:0]           is_ht_freq,
  output logic                           is_ht_last,
  output logic [DAT_WIDTH-1:0]           is_ht_sym_lo,
  output logic [DAT_WIDTH-1:0]           is_ht_sym_hi,
  output logic [DAT_WIDTH:0]             is_ht_sym_unique,
  output logic [SEQID_WIDTH-1:0]         is_ht_seq_id,
  output logic                           is_ht_err
);

  localparam int unsigned UW = count_width(MAX_NUM_SYM_USED);

  is_state_e state_q, state_d;

  logic [N_LANES-1:0]                    pend_q, pend_d;
  logic [N_LANES*DAT_WIDTH-1:0]          stg_sym_q, stg_sym_d;
  logic [N_LANES*CNT_WIDTH-1:0]          stg_cnt_q, stg_cnt_d;
  logic                                  stg_eob_q, stg_eob_d;
  logic [SEQID_WIDTH-1:0]                seq_q, seq_d;
  logic [MAX_NUM_SYM_USED-1:0][DAT_WIDTH-1:0] tbl_sym_q, tbl_sym_d, ins_sym;
  logic [MAX_NUM_SYM_USED-1:0][CNT_WIDTH-1:0] tbl_freq_q, tbl_freq_d, ins_freq;
  logic [UW-1:0]                         used_q, used_d, k_q, k_d;
  logic [DAT_WIDTH-1:0]                  lo_q, lo_d, hi_q, hi_d;
  logic                                  err_q, err_d;

  logic [N_LANES-1:0]   elig_in, pend_rest;
  logic                 cur_found, dup;
  logic [DAT_WIDTH-1:0] cur_sym, sel_sym;
  logic [CNT_WIDTH-1:0] cur_cnt, sel_freq;
  logic                 drain_last;

  cr_huf_comp_is_multi_ins #(
    .DAT_WIDTH (DAT_WIDTH),
    .CNT_WIDTH (CNT_WIDTH),
    .DEPTH     (MAX_NUM_SYM_USED),
    .UW        (UW)
  ) u_ins (
    .tbl_sym  (tbl_sym_q),
    .tbl_freq (tbl_freq_q),
    .used     (used_q),
    .new_sym  (cur_sym),
    .new_freq (cur_cnt),
    .ins_sym  (ins_sym),
    .ins_freq (ins_freq),
    .dup      (dup)
  );

  // Lanes worth a cycle of work (valid with nonzero count), and the lowest pending staged lane.
  always_comb begin
    elig_in   = '0;
    pend_rest = pend_q;
    cur_found = 1'b0;
    cur_sym   = '0;
    cur_cnt   = '0;
    for (int i = 0; i < N_LANES; i++) begin
      elig_in[i] = sc_is_vld[i] && (sc_is_cnt[i*CNT_WIDTH +: CNT_WIDTH] != '0);
      if (!cur_found && pend_q[i]) begin
        cur_found    = 1'b1;
        cur_sym      = stg_sym_q[i*DAT_WIDTH +: DAT_WIDTH];
        cur_cnt      = stg_cnt_q[i*CNT_WIDTH +: CNT_WIDTH];
        pend_rest[i] = 1'b0;
      end
    end
  end

  // Entry currently presented during drain.
  always_comb begin
    sel_sym  = '0;
    sel_freq = '0;
    for (int i = 0; i < MAX_NUM_SYM_USED; i++) begin
      if (k_q == UW'(i)) begin
        sel_sym  = tbl_sym_q[i];
        sel_freq = tbl_freq_q[i];
      end
    end
    drain_last = (used_q == '0) || ((k_q + UW'(1)) == used_q);
  end

  // Next-state logic: accept a beat, insert one lane per cycle, then drain the table.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    stg_sym_d  = stg_sym_q;
    stg_cnt_d  = stg_cnt_q;
    stg_eob_d  = stg_eob_q;
    seq_d      = seq_q;
    tbl_sym_d  = tbl_sym_q;
    tbl_freq_d = tbl_freq_q;
    used_d     = used_q;
    k_d        = k_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    err_d      = err_q;
    is_sc_rd   = 1'b0;

    unique case (state_q)
      StAccept: begin
        if (rst_n && ((sc_is_vld != '0) || sc_is_eob)) begin
          is_sc_rd  = 1'b1;
          stg_sym_d = sc_is_sym;
          stg_cnt_d = sc_is_cnt;
          stg_eob_d = sc_is_eob;
          seq_d     = sc_is_seq_id;
          pend_d    = elig_in;
          // Beats with nothing to insert skip the insert phase entirely.
          if (elig_in != '0)  state_d = StInsert;
          else if (sc_is_eob) state_d = StDrain;
        end
      end
      StInsert: begin
        if (cur_found) begin
          pend_d = pend_rest;
          if (dup || (used_q == UW'(MAX_NUM_SYM_USED))) begin
            err_d = 1'b1;
          end else begin
            tbl_sym_d  = ins_sym;
            tbl_freq_d = ins_freq;
            used_d     = used_q + UW'(1);
            if (used_q == '0) begin
              lo_d = cur_sym;
              hi_d = cur_sym;
            end else begin
              if (cur_sym < lo_q) lo_d = cur_sym;
              if (cur_sym > hi_q) hi_d = cur_sym;
            end
          end
        end
        if (pend_rest == '0) state_d = stg_eob_q ? StDrain : StAccept;
      end
      StDrain: begin
        if (!ht_is_not_ready) begin
          if (drain_last) begin
            state_d    = StAccept;
            pend_d     = '0;
            stg_eob_d  = 1'b0;
            seq_d      = '0;
            tbl_sym_d  = '0;
            tbl_freq_d = '0;
            used_d     = '0;
            k_d        = '0;
            lo_d       = '0;
            hi_d       = '0;
            err_d      = 1'b0;
          end else begin
            k_d = k_q + UW'(1);
          end
        end
      end
      default: state_d = StAccept;
    endcase
  end

  // State register with synchronous active-low reset; reset discards any partial block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StAccept;
      pend_q     <= '0;
      stg_sym_q  <= '0;
      stg_cnt_q  <= '0;
      stg_eob_q  <= 1'b0;
      seq_q      <= '0;
      tbl_sym_q  <= '0;
      tbl_freq_q <= '0;
      used_q     <= '0;
      k_q        <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      stg_sym_q  <= stg_sym_d;
      stg_cnt_q  <= stg_cnt_d;
      stg_eob_q  <= stg_eob_d;
      seq_q      <= seq_d;
      tbl_sym_q  <= tbl_sym_d;
      tbl_freq_q <= tbl_freq_d;
      used_q     <= used_d;
      k_q        <= k_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      err_q      <= err_d;
    end
  end

  // Output entry is visible only while draining; everything reads zero otherwise.
  always_comb begin
    is_ht_vld        = (state_q == StDrain);
    is_ht_sym        = is_ht_vld ? sel_sym : '0;
    is_ht_freq       = is_ht_vld ? sel_freq : '0;
    is_ht_last       = is_ht_vld && drain_last;
    is_ht_sym_lo     = is_ht_vld ? lo_q : '0;
    is_ht_sym_hi     = is_ht_vld ? hi_q : '0;
    is_ht_sym_unique = is_ht_vld ? (DAT_WIDTH+1)'(used_q) : '0;
    is_ht_seq_id     = is_ht_vld ? seq_q : '0;
    is_ht_err        = is_ht_vld && err_q;
  end

endmodule

// File: tb/tb_cr_huf_comp_is_multi.sv
// Scoreboard bench: stimulus pushes expected drain entries, a monitor pops on each transfer.
module tb_cr_huf_comp_is_multi;

  localparam int unsigned DW   = 6;
  localparam int unsigned CW   = 10;
  localparam int unsigned NL   = 4;
  localparam int unsigned MAXS = 4;
  localparam int unsigned SW   = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NL-1:0]    sc_is_vld;
  logic [NL*DW-1:0] sc_is_sym;
  logic [NL*CW-1:0] sc_is_cnt;
  logic [SW-1:0]    sc_is_seq_id;
  logic             sc_is_eob;
  logic             is_sc_rd;
  logic             ht_is_not_ready;
  logic             is_ht_vld;
  logic [DW-1:0]    is_ht_sym;
  logic [CW-1:0]    is_ht_freq;
  logic             is_ht_last;
  logic [DW-1:0]    is_ht_sym_lo;
  logic [DW-1:0]    is_ht_sym_hi;
  logic [DW:0]      is_ht_sym_unique;
  logic [SW-1:0]    is_ht_seq_id;
  logic             is_ht_err;

  always #5 clk = ~clk;

  cr_huf_comp_is_multi #(
    .DAT_WIDTH        (DW),
    .CNT_WIDTH        (CW),
    .N_LANES          (NL),
    .MAX_NUM_SYM_USED (MAXS),
    .SEQID_WIDTH      (SW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sc_is_vld        (sc_is_vld),
    .sc_is_sym        (sc_is_sym),
    .sc_is_cnt        (sc_is_cnt),
    .sc_is_seq_id     (sc_is_seq_id),
    .sc_is_eob        (sc_is_eob),
    .is_sc_rd         (is_sc_rd),
    .ht_is_not_ready  (ht_is_not_ready),
    .is_ht_vld        (is_ht_vld),
    .is_ht_sym        (is_ht_sym),
    .is_ht_freq       (is_ht_freq),
    .is_ht_last       (is_ht_last),
    .is_ht_sym_lo     (is_ht_sym_lo),
    .is_ht_sym_hi     (is_ht_sym_hi),
    .is_ht_sym_unique (is_ht_sym_unique),
    .is_ht_seq_id     (is_ht_seq_id),
    .is_ht_err        (is_ht_err)
  );

  typedef struct packed {
    logic [DW-1:0] sym;
    logic [CW-1:0] freq;
    logic          last;
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    logic [DW:0]   uniq;
    logic [SW-1:0] seq;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t got_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   rd_cnt = 0;

  function automatic logic [NL*DW-1:0] p6(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic logic [NL*CW-1:0] p10(input int a, input int b, input int c, input int d);
    return {CW'(d), CW'(c), CW'(b), CW'(a)};
  endfunction

  function automatic exp_t cur_out();
    exp_t o;
    o.sym  = is_ht_sym;
    o.freq = is_ht_freq;
    o.last = is_ht_last;
    o.lo   = is_ht_sym_lo;
    o.hi   = is_ht_sym_hi;
    o.uniq = is_ht_sym_unique;
    o.seq  = is_ht_seq_id;
    o.err  = is_ht_err;
    return o;
  endfunction

  task automatic push(input int sym, input int freq, input bit last, input int lo, input int hi,
                      input int uniq, input int seq, input bit err);
    exp_t e;
    e.sym  = DW'(sym);
    e.freq = CW'(freq);
    e.last = last;
    e.lo   = DW'(lo);
    e.hi   = DW'(hi);
    e.uniq = (DW+1)'(uniq);
    e.seq  = SW'(seq);
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic show_fail(input string name, input exp_t g, input exp_t w);
    $display("FAIL %s: got sym=%0d freq=%0d last=%0d lo=%0d hi=%0d uniq=%0d seq=%0d err=%0d | want sym=%0d freq=%0d last=%0d lo=%0d hi=%0d uniq=%0d seq=%0d err=%0d",
             name, g.sym, g.freq, g.last, g.lo, g.hi, g.uniq, g.seq, g.err,
             w.sym, w.freq, w.last, w.lo, w.hi, w.uniq, w.seq, w.err);
  endtask

  // Monitor: an entry transfers on the next rising edge when valid and not stalled.
  always @(negedge clk) begin
    if (is_sc_rd) rd_cnt++;
    if (rst_n && is_ht_vld && !ht_is_not_ready) begin
      got_e = cur_out();
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_entry: got sym=%0d freq=%0d, want no entry", got_e.sym,
                 got_e.freq);
      end else begin
        mon_e = exp_q.pop_front();
        if (got_e === mon_e) n_pass++;
        else show_fail("drain_entry", got_e, mon_e);
      end
    end
  end

  // Offer one beat from posedge+1 and hold it until consumed.
  task automatic send(input logic [NL-1:0] vld, input logic [NL*DW-1:0] sym,
                      input logic [NL*CW-1:0] cnt, input int seq, input bit eob);
    bit got;
    sc_is_vld    = vld;
    sc_is_sym    = sym;
    sc_is_cnt    = cnt;
    sc_is_seq_id = SW'(seq);
    sc_is_eob    = eob;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (is_sc_rd) got = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!got) begin
      n_chk++;
      $display("FAIL beat_accept_timeout: got no is_sc_rd, want a pulse");
    end
    sc_is_vld = '0;
    sc_is_sym = '0;
    sc_is_cnt = '0;
    sc_is_eob = 1'b0;
    sc_is_seq_id = '0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else begin
      $display("FAIL %s_drain_timeout: got %0d entries left, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_zero(input string name);
    logic [63:0] all;
    all = {is_sc_rd, is_ht_vld, is_ht_sym, is_ht_freq, is_ht_last, is_ht_sym_lo,
           is_ht_sym_hi, is_ht_sym_unique, is_ht_seq_id, is_ht_err};
    n_chk++;
    if (all == '0) n_pass++;
    else $display("FAIL %s: got outputs 0x%0h, want 0", name, all);
  endtask

  task automatic wait_vld(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (is_ht_vld) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++;
      $display("FAIL %s_vld_timeout: got is_ht_vld=0, want 1", name);
    end
  endtask

  initial begin
    exp_t w;
    rst_n           = 1'b0;
    sc_is_vld       = '0;
    sc_is_sym       = '0;
    sc_is_cnt       = '0;
    sc_is_seq_id    = '0;
    sc_is_eob       = 1'b0;
    ht_is_not_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_zero("reset_outputs");

    // Single beat, four lanes, freq ties broken by symbol.
    push(7, 2, 0, 1, 7, 4, 5, 0);
    push(5, 4, 0, 1, 7, 4, 5, 0);
    push(1, 9, 0, 1, 7, 4, 5, 0);
    push(3, 9, 1, 1, 7, 4, 5, 0);
    send(4'b1111, p6(3, 7, 1, 5), p10(9, 2, 9, 4), 5, 1'b1);
    wait_drain("one_beat");

    // Same symbols split over two beats.
    rd_cnt = 0;
    push(7, 2, 0, 1, 7, 4, 6, 0);
    push(5, 4, 0, 1, 7, 4, 6, 0);
    push(1, 9, 0, 1, 7, 4, 6, 0);
    push(3, 9, 1, 1, 7, 4, 6, 0);
    send(4'b0011, p6(3, 7, 0, 0), p10(9, 2, 0, 0), 6, 1'b0);
    send(4'b0011, p6(1, 5, 0, 0), p10(9, 4, 0, 0), 6, 1'b1);
    wait_drain("two_beat");
    n_chk++;
    if (rd_cnt == 2) n_pass++;
    else $display("FAIL two_beat_rd_pulses: got %0d, want 2", rd_cnt);

    // Empty block.
    push(0, 0, 1, 0, 0, 0, 2, 0);
    send(4'b0000, p6(0, 0, 0, 0), p10(0, 0, 0, 0), 2, 1'b1);
    wait_drain("empty");

    // Overflow: six distinct symbols into a four-entry table.
    push(13, 1, 0, 10, 13, 4, 4, 1);
    push(12, 2, 0, 10, 13, 4, 4, 1);
    push(11, 3, 0, 10, 13, 4, 4, 1);
    push(10, 4, 1, 10, 13, 4, 4, 1);
    send(4'b1111, p6(10, 11, 12, 13), p10(4, 3, 2, 1), 4, 1'b0);
    send(4'b0011, p6(14, 15, 0, 0), p10(1, 6, 0, 0), 4, 1'b1);
    wait_drain("overflow");

    // Duplicate symbol in lanes 0 and 2.
    push(3, 5, 1, 3, 3, 1, 7, 1);
    send(4'b0101, p6(3, 0, 3, 0), p10(5, 0, 8, 0), 7, 1'b1);
    wait_drain("duplicate");

    // Stall for five cycles on the first drained entry.
    ht_is_not_ready = 1'b1;
    push(22, 3, 0, 20, 23, 4, 11, 0);
    push(20, 7, 0, 20, 23, 4, 11, 0);
    push(21, 7, 0, 20, 23, 4, 11, 0);
    push(23, 100, 1, 20, 23, 4, 11, 0);
    send(4'b1111, p6(20, 21, 22, 23), p10(7, 7, 3, 100), 11, 1'b1);
    wait_vld("stall");
    w = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      got_e = cur_out();
      n_chk++;
      if (is_ht_vld && got_e === w) n_pass++;
      else show_fail("stall_hold", got_e, w);
    end
    @(posedge clk);
    #1;
    ht_is_not_ready = 1'b0;
    wait_drain("stall");

    // Reset while a block is waiting to drain; it must be discarded.
    ht_is_not_ready = 1'b1;
    send(4'b0011, p6(1, 2, 0, 0), p10(5, 6, 0, 0), 9, 1'b1);
    wait_vld("reset_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_zero("reset_mid_drain");
    ht_is_not_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push(7, 2, 0, 1, 7, 4, 3, 0);
    push(5, 4, 0, 1, 7, 4, 3, 0);
    push(1, 9, 0, 1, 7, 4, 3, 0);
    push(3, 9, 1, 1, 7, 4, 3, 0);
    send(4'b1111, p6(3, 7, 1, 5), p10(9, 2, 9, 4), 3, 1'b1);
    wait_drain("after_reset");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
